// File: rtl/sdram_cmd_sched.sv
// sdram_cmd_sched: turns opcode/operand byte pairs from the opcode detector
// into SDRAM write/read requests, holds one command while busy and streams
// read data back out on dout.
// Optional build macro SDRAM_ADDR_AUTOINC_EN: when defined, the address
// register advances by 1 after each acknowledged WRITE and by the beat count
// after each completed READ (modulo 2^ADDR_W).
module sdram_cmd_sched #(
  parameter int ADDR_W   = 16,
  parameter int PAIR_TMO = 64,
  parameter int ACK_TMO  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        din,
  input  logic              din_vld,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ack,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_len,
  input  logic              rd_ack,
  input  logic [7:0]        rd_data,
  input  logic              rd_data_vld,
  output logic [7:0]        dout,
  output logic              dout_vld,
  output logic              busy,
  output logic              cmd_err,
  output logic              cmd_drop,
  output logic              timeout
);

  localparam int PT_W = $clog2(PAIR_TMO + 1);
  localparam int AT_W = $clog2(ACK_TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WR_REQ,
    S_RD_REQ,
    S_RD_DATA
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              pair_cnt;
  logic [PT_W-1:0]   pair_tmr;
  logic [7:0]        opc_hold;
  logic              slot_full;
  logic [15:0]       slot_word;
  logic [7:0]        cmd_opc;
  logic [7:0]        cmd_opr;
  logic [ADDR_W-1:0] addr;
  logic [AT_W-1:0]   tmo_cnt;
  logic [7:0]        beat_cnt;

  logic              word_done;
  logic              slot_load;
  logic              consume;
  logic              tmo_hit;
  logic              beat;
  logic              err_set;
  logic              tmo_set;
  logic              wr_done;
  logic              rd_done;

  // Wrapping address advance; the carry out of the top bit is discarded.
  function automatic logic [ADDR_W-1:0] addr_add(input logic [ADDR_W-1:0] a,
                                                 input logic [7:0]        n);
    addr_add = a + ADDR_W'(n);
  endfunction

  assign word_done = din_vld & pair_cnt;
  assign consume   = (state == S_IDLE) & slot_full;
  // A finished word may reuse the slot in the cycle the FSM empties it.
  assign slot_load = word_done & (~slot_full | consume);
  assign tmo_hit   = (tmo_cnt == AT_W'(ACK_TMO - 1));
  assign beat      = (state == S_RD_DATA) & rd_data_vld;

  assign wr_req  = (state == S_WR_REQ);
  assign rd_req  = (state == S_RD_REQ);
  assign wr_addr = addr;
  assign rd_addr = addr;
  assign wr_data = cmd_opr;
  assign rd_len  = cmd_opr;
  assign busy    = (state != S_IDLE) | slot_full;

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    tmo_set   = 1'b0;
    wr_done   = 1'b0;
    rd_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (slot_full) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (cmd_opc)
          8'h00, 8'h01, 8'h02, 8'h05: state_nxt = S_IDLE;
          8'h03: state_nxt = S_WR_REQ;
          8'h04: begin
            if (cmd_opr != 8'd0) begin
              state_nxt = S_RD_REQ;
            end else begin
              err_set   = 1'b1;
              state_nxt = S_IDLE;
            end
          end
          default: begin
            err_set   = 1'b1;
            state_nxt = S_IDLE;
          end
        endcase
      end
      S_WR_REQ: begin
        if (wr_ack) begin
          wr_done   = 1'b1;
          state_nxt = S_IDLE;
        end else if (tmo_hit) begin
          tmo_set   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_RD_REQ: begin
        if (rd_ack) begin
          state_nxt = S_RD_DATA;
        end else if (tmo_hit) begin
          tmo_set   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_RD_DATA: begin
        if (beat) begin
          if (beat_cnt + 8'd1 == cmd_opr) begin
            rd_done   = 1'b1;
            state_nxt = S_IDLE;
          end
        end else if (tmo_hit) begin
          tmo_set   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage boundary: byte pairing and the one-deep pending slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_cnt  <= 1'b0;
      pair_tmr  <= '0;
      slot_full <= 1'b0;
      cmd_drop  <= 1'b0;
    end else begin
      if (din_vld) begin
        pair_cnt <= ~pair_cnt;
        pair_tmr <= '0;
      end else if (pair_cnt) begin
        if (pair_tmr == PT_W'(PAIR_TMO - 1)) pair_cnt <= 1'b0;
        else                                 pair_tmr <= pair_tmr + 1'b1;
      end
      if (slot_load)    slot_full <= 1'b1;
      else if (consume) slot_full <= 1'b0;
      cmd_drop <= word_done & ~slot_load;
    end
  end

  always_ff @(posedge clk) begin
    if (din_vld && !pair_cnt) opc_hold <= din;
    if (slot_load)            slot_word <= {opc_hold, din};
  end

  // Stage boundary: command execution, address register and read return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cmd_opc  <= 8'd0;
      cmd_opr  <= 8'd0;
      addr     <= '0;
      tmo_cnt  <= '0;
      beat_cnt <= 8'd0;
      dout     <= 8'd0;
      dout_vld <= 1'b0;
      cmd_err  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cmd_err <= err_set;
      timeout <= tmo_set;
      if (consume) begin
        cmd_opc <= slot_word[15:8];
        cmd_opr <= slot_word[7:0];
      end
      if (state_nxt != state || beat) tmo_cnt <= '0;
      else if (!tmo_hit)              tmo_cnt <= tmo_cnt + 1'b1;
      if (state_nxt == S_RD_DATA && state != S_RD_DATA) beat_cnt <= 8'd0;
      else if (beat)                                    beat_cnt <= beat_cnt + 8'd1;
      dout_vld <= beat;
      if (beat) dout <= rd_data;
      if (state == S_DECODE) begin
        case (cmd_opc)
          8'h01:   addr[ADDR_W-1:8] <= cmd_opr[ADDR_W-9:0];
          8'h02:   addr[7:0]        <= cmd_opr;
          8'h05:   addr             <= '0;
          default: addr             <= addr;
        endcase
      end
`ifdef SDRAM_ADDR_AUTOINC_EN
      else if (wr_done) begin
        addr <= addr_add(addr, 8'd1);
      end else if (rd_done) begin
        addr <= addr_add(addr, cmd_opr);
      end
`endif
    end
  end

endmodule

// File: tb/tb_sdram_cmd_sched.sv
// Scoreboard bench for sdram_cmd_sched: stimulus pushes expected output
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_sdram_cmd_sched;

  localparam int K_WR   = 1;
  localparam int K_RD   = 2;
  localparam int K_DO   = 3;
  localparam int K_ERR  = 4;
  localparam int K_DROP = 5;
  localparam int K_TMO  = 6;

`ifdef SDRAM_ADDR_AUTOINC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif

  typedef struct {
    int          kind;
    logic [15:0] a;
    logic [15:0] b;
  } ev_t;

  logic        clk;
  logic        rst;
  logic [7:0]  din;
  logic        din_vld;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic [7:0]  rd_len;
  logic        rd_ack;
  logic [7:0]  rd_data;
  logic        rd_data_vld;
  logic [7:0]  dout;
  logic        dout_vld;
  logic        busy;
  logic        cmd_err;
  logic        cmd_drop;
  logic        timeout;

  ev_t sb_q[$];
  int  n_chk  = 0;
  int  n_pass = 0;
  bit  wr_q   = 1'b0;
  bit  rd_q   = 1'b0;

  sdram_cmd_sched dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_vld     (din_vld),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_len      (rd_len),
    .rd_ack      (rd_ack),
    .rd_data     (rd_data),
    .rd_data_vld (rd_data_vld),
    .dout        (dout),
    .dout_vld    (dout_vld),
    .busy        (busy),
    .cmd_err     (cmd_err),
    .cmd_drop    (cmd_drop),
    .timeout     (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic push(input int kind, input logic [15:0] a, input logic [15:0] b);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    sb_q.push_back(e);
  endtask

  task automatic expect_ev(input int kind, input logic [15:0] a, input logic [15:0] b);
    ev_t e;
    n_chk++;
    if (sb_q.size() == 0) begin
      $display("FAIL unexpected_event: got kind=%0d a=%h b=%h required no event", kind, a, b);
    end else begin
      e = sb_q.pop_front();
      if (e.kind == kind && e.a === a && e.b === b) n_pass++;
      else $display("FAIL event: got kind=%0d a=%h b=%h required kind=%0d a=%h b=%h",
                    kind, a, b, e.kind, e.a, e.b);
    end
  endtask

  // Monitor: every output event is matched against the scoreboard in order.
  always @(negedge clk) begin
    if (rst) begin
      wr_q = 1'b0;
      rd_q = 1'b0;
    end else begin
      if (wr_req && !wr_q) expect_ev(K_WR, wr_addr, {8'h00, wr_data});
      if (rd_req && !rd_q) expect_ev(K_RD, rd_addr, {8'h00, rd_len});
      if (dout_vld)        expect_ev(K_DO, {8'h00, dout}, 16'h0000);
      if (cmd_err)         expect_ev(K_ERR, 16'h0000, 16'h0000);
      if (cmd_drop)        expect_ev(K_DROP, 16'h0000, 16'h0000);
      if (timeout)         expect_ev(K_TMO, 16'h0000, 16'h0000);
      wr_q = wr_req;
      rd_q = rd_req;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    din     = b;
    din_vld = 1'b1;
    @(posedge clk);
    #1;
    din_vld = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] opc, input logic [7:0] opr);
    send_byte(opc);
    send_byte(opr);
  endtask

  task automatic wait_wr();
    int n = 0;
    while (!wr_req && n < 50) begin
      idle(1);
      n++;
    end
    chk("wr_req_seen", {31'd0, wr_req}, 32'd1);
  endtask

  task automatic wait_rd();
    int n = 0;
    while (!rd_req && n < 50) begin
      idle(1);
      n++;
    end
    chk("rd_req_seen", {31'd0, rd_req}, 32'd1);
  endtask

  task automatic ack_wr();
    wr_ack = 1'b1;
    idle(1);
    wr_ack = 1'b0;
    chk("wr_req_after_ack", {31'd0, wr_req}, 32'd0);
  endtask

  task automatic ack_rd();
    rd_ack = 1'b1;
    idle(1);
    rd_ack = 1'b0;
    chk("rd_req_after_ack", {31'd0, rd_req}, 32'd0);
  endtask

  task automatic send_beat(input logic [7:0] b);
    rd_data     = b;
    rd_data_vld = 1'b1;
    idle(1);
    rd_data_vld = 1'b0;
    chk("dout_latency", {23'd0, dout_vld, dout}, {23'd0, 1'b1, b});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {30'd0, wr_req, rd_req}, 32'd0);
    chk({tag, "_addr"},  {16'd0, wr_addr}, 32'd0);
    chk({tag, "_dout"},  {23'd0, dout_vld, dout}, 32'd0);
    chk({tag, "_flags"}, {28'd0, busy, cmd_err, cmd_drop, timeout}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, wr_data, rd_len}, 32'd0);
  endtask

  initial begin
    int n;
    logic [15:0] a;
    rst = 1'b1;
    din = 8'h00;
    din_vld = 1'b0;
    wr_ack = 1'b0;
    rd_ack = 1'b0;
    rd_data = 8'h00;
    rd_data_vld = 1'b0;
    idle(3);
    chk_reset_outputs("reset");
    rst = 1'b0;
    idle(2);

    // Address then write
    push(K_WR, 16'h1234, 16'h00A5);
    send_pair(8'h01, 8'h12);
    send_pair(8'h02, 8'h34);
    send_pair(8'h03, 8'hA5);
    wait_wr();
    idle(3);
    ack_wr();
    chk("addr_after_write", {16'd0, wr_addr}, AI ? 32'h1235 : 32'h1234);

    // Read of three beats with gaps
    push(K_RD, 16'h0010, 16'h0003);
    push(K_DO, 16'h0011, 16'h0000);
    push(K_DO, 16'h0022, 16'h0000);
    push(K_DO, 16'h0033, 16'h0000);
    send_pair(8'h05, 8'h00);
    send_pair(8'h02, 8'h10);
    send_pair(8'h04, 8'h03);
    wait_rd();
    ack_rd();
    send_beat(8'h11);
    idle(2);
    send_beat(8'h22);
    idle(2);
    send_beat(8'h33);
    chk("busy_after_read", {31'd0, busy}, 32'd0);
    chk("addr_after_read", {16'd0, rd_addr}, AI ? 32'h0013 : 32'h0010);
    rd_data     = 8'hEE;
    rd_data_vld = 1'b1;
    idle(1);
    rd_data_vld = 1'b0;
    chk("stray_beat_ignored", {31'd0, dout_vld}, 32'd0);
    idle(2);

    // Illegal opcode and zero-length read
    push(K_ERR, 16'h0000, 16'h0000);
    send_pair(8'h07, 8'h00);
    idle(5);
    push(K_ERR, 16'h0000, 16'h0000);
    send_pair(8'h04, 8'h00);
    idle(5);

    // Overflow: one buffered, one dropped
    send_pair(8'h01, 8'h00);
    send_pair(8'h02, 8'h40);
    push(K_WR, 16'h0040, 16'h005A);
    send_pair(8'h03, 8'h5A);
    wait_wr();
    send_pair(8'h03, 8'h6B);
    push(K_DROP, 16'h0000, 16'h0000);
    send_pair(8'h03, 8'h7C);
    idle(2);
    chk("busy_while_pending", {31'd0, busy}, 32'd1);
    push(K_WR, AI ? 16'h0041 : 16'h0040, 16'h006B);
    ack_wr();
    wait_wr();
    ack_wr();
    idle(1);
    chk("busy_after_overflow", {31'd0, busy}, 32'd0);
    a = AI ? 16'h0042 : 16'h0040;
    chk("addr_after_overflow", {16'd0, wr_addr}, {16'd0, a});

    // Write acknowledge timeout
    push(K_WR, a, 16'h0099);
    push(K_TMO, 16'h0000, 16'h0000);
    send_pair(8'h03, 8'h99);
    wait_wr();
    n = 0;
    while (wr_req && n < 2000) begin
      idle(1);
      n++;
    end
    chk("wr_req_hold_cycles", n, 32'd1024);
    chk("timeout_state", {29'd0, timeout, wr_req, busy}, 32'b100);
    chk("addr_after_timeout", {16'd0, wr_addr}, {16'd0, a});
    idle(2);

    // Lone byte 0 discarded after the pair timeout
    send_byte(8'h03);
    idle(64);
    send_pair(8'h02, 8'h77);
    push(K_WR, 16'h0077, 16'h0001);
    send_pair(8'h03, 8'h01);
    wait_wr();
    ack_wr();
    chk("addr_after_discard", {16'd0, wr_addr}, AI ? 32'h0078 : 32'h0077);

    // Address wrap
    send_pair(8'h01, 8'hFF);
    send_pair(8'h02, 8'hFF);
    push(K_WR, 16'hFFFF, 16'h00EE);
    send_pair(8'h03, 8'hEE);
    wait_wr();
    ack_wr();
    chk("addr_wrap", {16'd0, wr_addr}, AI ? 32'h0000 : 32'hFFFF);

    // Reset in the middle of a read
    push(K_RD, AI ? 16'h0000 : 16'hFFFF, 16'h0005);
    push(K_DO, 16'h0044, 16'h0000);
    send_pair(8'h04, 8'h05);
    wait_rd();
    ack_rd();
    send_beat(8'h44);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midread_reset");
    idle(2);
    rst = 1'b0;
    idle(4);
    chk("scoreboard_drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
